// File: rtl/sram_controller.sv
// MEM-stage load/store responder: one 32-bit word access as two 16-bit SRAM transfers,
// with a ready flag that freezes the pipeline until the access completes.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {StIdle, StAccLo, StAccHi, StFinish} state_e;

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [16:0]     word_q;
    logic [31:0]     wdata_q;
    logic            is_write_q;
    logic            accept;
    logic            half_last;
    logic            dq_oe;
    logic [15:0]     dq_out;
    logic [31:0]     offset;
    logic            unused_offset;

    // Wraps on underflow; only the word index bits reach the SRAM.
    assign offset        = address - BASE_ADDR;
    assign unused_offset = ^{offset[31:19], offset[1:0]};
    assign half_last     = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        ready     = 1'b1;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        unique case (state_q)
            StIdle: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StAccLo;
                end
            end
            StAccLo: begin
                ready     = 1'b0;
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~is_write_q;
                dq_oe     = is_write_q;
                if (half_last) begin
                    cnt_d   = '0;
                    state_d = StAccHi;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccHi: begin
                ready     = 1'b0;
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~is_write_q;
                dq_oe     = is_write_q;
                dq_out    = wdata_q[31:16];
                if (half_last) begin
                    cnt_d   = '0;
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; wr_en wins when both strobes are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else if (accept) begin
            word_q     <= offset[18:2];
            wdata_q    <= writeData;
            is_write_q <= wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readData <= '0;
        end else if (!is_write_q && half_last) begin
            if (state_q == StAccLo) readData[15:0] <= SRAM_DQ;
            if (state_q == StAccHi) readData[31:16] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of word accesses against a small SRAM model,
// plus mid-access reset and a WAIT_CYCLES=1 latency sequence.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0;
    logic [31:0] rdata1;
    logic        ready1;
    wire  [15:0] dq1;
    logic [17:0] sa1;
    logic        we1, ub1, lb1, ce1, oe1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:63];

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .writeData(wd1), .readData(rdata1), .ready(ready1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .SRAM_UB_N(ub1),
        .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // SRAM model: OE tied low, so it drives whenever WE_N is high.
    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hold;
        logic [31:0] addr;
        logic [31:0] data;
        logic [17:0] lo;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic run_access(input vec_t v);
        @(posedge clk); #1;
        rd_en = v.rd; wr_en = v.wr; address = v.addr; writeData = v.data;
        @(negedge clk);
        check("ready_c0", {31'b0, ready}, 32'd0);
        for (int c = 1; c <= 2 * W + 1; c++) begin
            @(posedge clk); #1;
            if ((c == 1 && !v.hold) || c == 2 * W + 1) begin
                rd_en = 1'b0; wr_en = 1'b0; address = 32'hFFFF_FFF0; writeData = '0;
            end
            @(negedge clk);
            if (c <= 2 * W) begin
                check("ready_acc", {31'b0, ready}, 32'd0);
                check("sram_addr", {14'b0, SRAM_ADDR},
                      {14'b0, (c <= W) ? v.lo : (v.lo | 18'd1)});
                check("we_n", {31'b0, SRAM_WE_N}, {31'b0, ~v.wr});
                if (v.wr)
                    check("dq_write", {16'b0, SRAM_DQ},
                          {16'b0, (c <= W) ? v.data[15:0] : v.data[31:16]});
            end else begin
                check("ready_finish", {31'b0, ready}, 32'd1);
                check("addr_finish", {14'b0, SRAM_ADDR}, 32'd0);
                check("read_data", readData, v.exp_rd);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'd1024, 32'h1, 18'd0, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'h00000001};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd1035, 32'hCAFEF00D, 18'd4, 32'h00000001};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd1034, 32'h0, 18'd4, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'd1020, 32'h12345678, 18'h3FFFE, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'h12345678};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'd1424, 32'hA5A55A5A, 18'd200, 32'h12345678};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 32'd1424, 32'h0, 18'd200, 32'hA5A55A5A};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_addr", {14'b0, SRAM_ADDR}, 32'd0);
        check("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("rst_rdata", readData, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Consecutive calls present each request in the idle cycle right after FINISH.
        for (int i = 0; i < 10; i++) run_access(vecs[i]);

        // No duplicate access once strobes are gone.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, ready}, 32'd1);
            check("idle_addr", {14'b0, SRAM_ADDR}, 32'd0);
            check("idle_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        end

        // Reset during a write in ACC_HI.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1032; writeData = 32'h11112222;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_addr", {14'b0, SRAM_ADDR}, 32'd5);
        check("pre_rst_we_n", {31'b0, SRAM_WE_N}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("mid_rst_addr", {14'b0, SRAM_ADDR}, 32'd0);
        check("mid_rst_rdata", readData, 32'd0);
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        check("mid_rst_dq_released", {16'b0, SRAM_DQ}, 32'h0001);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_retry_addr", {14'b0, SRAM_ADDR}, 32'd0);
            check("no_retry_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        end

        // WAIT_CYCLES=1 instance, strobe dropped in ACC_LO: ready in cycle 3.
        @(posedge clk); #1;
        wr1 = 1'b1; addr1 = 32'd1028; wd1 = 32'h000000FF;
        @(negedge clk);
        check("w1_ready_c0", {31'b0, ready1}, 32'd0);
        @(posedge clk); #1;
        wr1 = 1'b0; addr1 = '0; wd1 = '0;
        @(negedge clk);
        check("w1_ready_c1", {31'b0, ready1}, 32'd0);
        check("w1_addr_c1", {14'b0, sa1}, 32'd2);
        check("w1_dq_c1", {16'b0, dq1}, 32'h00FF);
        check("w1_we_c1", {31'b0, we1}, 32'd0);
        @(negedge clk);
        check("w1_ready_c2", {31'b0, ready1}, 32'd0);
        check("w1_addr_c2", {14'b0, sa1}, 32'd3);
        check("w1_dq_c2", {16'b0, dq1}, 32'h0000);
        @(negedge clk);
        check("w1_ready_c3", {31'b0, ready1}, 32'd1);
        check("w1_addr_c3", {14'b0, sa1}, 32'd0);
        @(negedge clk);
        check("w1_ready_c4", {31'b0, ready1}, 32'd1);
        check("w1_rdata", rdata1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
